// File: rtl/sha2_pkg.sv
// -----------------------------------------------------------------------------
// sha2_pkg
// Shared definitions for the SHA-2 round-constant path:
//   - round counts for the 32-bit (SHA-224/256) and 64-bit (SHA-384/512) modes
//   - round index width, common to both modes
//   - sequencer state encoding
//   - FIPS 180-4 round-constant tables and lookup functions
// -----------------------------------------------------------------------------
package sha2_pkg;

   localparam int SHA256_ROUNDS = 64;
   localparam int SHA512_ROUNDS = 80;

   // Wide enough for 0..79 so both modes share one index format.
   localparam int IDX_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   localparam logic [31:0] K256_TAB [SHA256_ROUNDS] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [63:0] K512_TAB [SHA512_ROUNDS] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   // SHA-256 constant for rounds 0..63; the 6-bit index covers the table exactly.
   function automatic logic [31:0] k256(input logic [5:0] i);
      return K256_TAB[i];
   endfunction

   // SHA-512 constant for rounds 0..79; indices 80..127 are illegal and read as 0.
   function automatic logic [63:0] k512(input logic [IDX_W-1:0] i);
      logic [63:0] k;
      k = '0;
      if (i < IDX_W'(SHA512_ROUNDS)) k = K512_TAB[i];
      return k;
   endfunction

endpackage

// File: rtl/sha_k_rom.sv
// -----------------------------------------------------------------------------
// sha_k_rom
// Purely combinational round-constant lookup. Selects the SHA-256 table for
// WORD_W=32 and the SHA-512 table for WORD_W=64. Any index beyond the round
// count of the selected mode returns 0.
// Ports:
//   idx  in   IDX_W   round index
//   k    out  WORD_W  round constant for idx
// -----------------------------------------------------------------------------
module sha_k_rom
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [WORD_W-1:0] k
);

   if (WORD_W == 64) begin : g_k512
      always_comb k = k512(idx);
   end else if (WORD_W == 32) begin : g_k256
      always_comb begin
         k = '0;
         if (idx < IDX_W'(SHA256_ROUNDS)) k = k256(idx[5:0]);
      end
   end else begin : g_bad_word_w
      $error("sha_k_rom: WORD_W must be 32 or 64");
   end

endmodule

// File: rtl/sha_k_sequencer.sv
// -----------------------------------------------------------------------------
// sha_k_sequencer
// Round-constant sequencer between the block controller and the SHA-2
// compression datapath. A start in IDLE launches a sequence of NUM_ROUNDS
// rounds; each cycle presents a registered round index and its constant.
// The consumer may stall at any round (including the last) or abort.
// Ports:
//   clk        in   1       system clock
//   reset      in   1       synchronous, active-high reset
//   start      in   1       request a new sequence, honoured only in IDLE
//   stall      in   1       hold the current round, outputs frozen
//   abort      in   1       drop the sequence and return to IDLE (RUN only)
//   busy       out  1       high while in RUN
//   k_valid    out  1       round_idx/K are valid this cycle
//   round_idx  out  IDX_W   current round number
//   K          out  WORD_W  round constant for round_idx
//   last       out  1       high with round NUM_ROUNDS-1
//   done       out  1       one-cycle pulse after the final round is consumed
// -----------------------------------------------------------------------------
module sha_k_sequencer
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              abort,
   output logic              busy,
   output logic              k_valid,
   output logic [IDX_W-1:0]  round_idx,
   output logic [WORD_W-1:0] K,
   output logic              last,
   output logic              done
);

   localparam int NUM_ROUNDS = (WORD_W == 64) ? SHA512_ROUNDS : SHA256_ROUNDS;

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("sha_k_sequencer: WORD_W must be 32 or 64");
   end

   seq_state_t         state;
   logic [IDX_W-1:0]   idx_p0;
   logic [WORD_W-1:0]  k_p0;

   // ---- stage p0: index of the round that will be presented after this edge
   // Starting from IDLE always loads round 0; in RUN the look-ahead index is
   // the next round, and it wraps to 0 on the last round so the ROM is never
   // addressed out of range.
   always_comb begin
      idx_p0 = '0;
      if (state == ST_RUN && !last) idx_p0 = round_idx + IDX_W'(1);
   end

   sha_k_rom #(
      .WORD_W (WORD_W)
   ) u_rom (
      .idx (idx_p0),
      .k   (k_p0)
   );

   // ---- stage p1: registered FSM, round counter and constant
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         k_valid   <= 1'b0;
         last      <= 1'b0;
         done      <= 1'b0;
         round_idx <= '0;
         K         <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_RUN;
                  busy      <= 1'b1;
                  k_valid   <= 1'b1;
                  round_idx <= '0;
                  K         <= k_p0;
                  last      <= 1'b0;
               end
            end
            ST_RUN: begin
               // Abort wins over stall; no done pulse for an aborted block.
               if (abort) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  k_valid   <= 1'b0;
                  last      <= 1'b0;
                  round_idx <= '0;
                  K         <= '0;
               end else if (!stall) begin
                  if (last) begin
                     state     <= ST_DONE;
                     busy      <= 1'b0;
                     k_valid   <= 1'b0;
                     last      <= 1'b0;
                     round_idx <= '0;
                     K         <= '0;
                     done      <= 1'b1;
                  end else begin
                     round_idx <= idx_p0;
                     K         <= k_p0;
                     last      <= (round_idx == IDX_W'(NUM_ROUNDS - 2));
                  end
               end
            end
            ST_DONE: begin
               // Start is deliberately not sampled here; requester re-asserts in IDLE.
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Index must stay inside the table of the selected mode.
   a_round_idx_range : assert property (@(posedge clk) disable iff (reset)
      round_idx < IDX_W'(NUM_ROUNDS));
   a_rom_idx_range : assert property (@(posedge clk) disable iff (reset)
      idx_p0 < IDX_W'(NUM_ROUNDS));

endmodule

// File: doc/sha_k_sequencer.md
Name: sha_k_sequencer

Overview:
Parametrised round-constant sequencer for the SHA-2 compression cores. It supports WORD_W=32 (SHA-224/256, 64 rounds) and WORD_W=64 (SHA-384/512, 80 rounds). On a start handshake it steps through every round and presents a registered round index and round constant each cycle. It supports stall, abort and an end-of-block flag. It sits between the block controller and the compression datapath, so the datapath no longer indexes a constant table itself.

Parameters:
- WORD_W, 32, constant word width; legal values are 32 and 64 only, and any other value is an elaboration error.
- NUM_ROUNDS, derived (not overridable): 64 when WORD_W=32, 80 when WORD_W=64.
- IDX_W, derived: 7 (wide enough for 0..79 in both modes).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a new round sequence; sampled only in IDLE
- stall  in  1  hold the current round; outputs frozen
- abort  in  1  terminate the sequence and return to IDLE
- busy  out  1  high in RUN
- k_valid  out  1  round_idx and K are valid this cycle
- round_idx  out  IDX_W  current round number
- K  out  WORD_W  round constant for round_idx
- last  out  1  high with the final round (round_idx = NUM_ROUNDS-1)
- done  out  1  one-cycle pulse after the final round is consumed

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (synchronous, active-high) has priority over every other input:
  - state is IDLE;
  - busy, k_valid, last and done are 0;
  - round_idx is 0 and K is 0.
- IDLE:
  - start=1 moves to RUN on the next edge, with round_idx=0, K=K[0] and k_valid=1. Latency from the start edge to the first valid constant is 1 cycle.
  - stall and abort are ignored in IDLE.
- RUN:
  - stall=0: round_idx increments by 1 and K is updated to K[round_idx+1] in the same edge.
  - stall=1: round_idx, K, k_valid and last all hold. The consumer may stall any number of cycles, including on the last round.
  - last=1 exactly when round_idx = NUM_ROUNDS-1 and k_valid=1.
  - An unstalled cycle with last=1 moves to DONE: k_valid=0, last=0, round_idx wraps to 0, and done=1 for 1 cycle.
- DONE: returns unconditionally to IDLE on the next edge with done=0. A start asserted during DONE is ignored; the requester must hold or re-assert start in IDLE.
- abort=1 in RUN (takes priority over stall):
  - next state is IDLE, k_valid=0, round_idx=0;
  - done is not pulsed.
- start asserted in RUN or DONE is ignored; a sequence is never restarted mid-flight.
- Throughput: one new block every NUM_ROUNDS+2 cycles minimum (start, NUM_ROUNDS valid cycles, DONE).
- round_idx never exceeds NUM_ROUNDS-1. Any out-of-range index value is treated as illegal: the ROM returns 0, and an assertion flags it in simulation.
- Constant values:
  - WORD_W=32: the 64 FIPS 180-4 SHA-256 constants.
  - WORD_W=64: the 80 FIPS 180-4 SHA-512 constants. The upper 32 bits of the first 64 entries equal the SHA-256 constants.

Decomposition:
- Package sha2_pkg holds:
  - SHA256_ROUNDS=64 and SHA512_ROUNDS=80;
  - K256 table function (6-bit index → 32-bit);
  - K512 table function (7-bit index → 64-bit).
- Sub-module sha_k_rom (parameter WORD_W): purely combinational mux from index to constant, selecting K256 or K512 from the package. The sequencer registers its output.
- The FSM and round counter live in sha_k_sequencer.

Test Plan:
- WORD_W=32, reset then start pulse:
  - cycle+1: k_valid=1, round_idx=0, K=32'h428a2f98;
  - round 63: K=32'hc67178f2 with last=1;
  - next cycle: done=1 for exactly 1 cycle, then busy=0.
- WORD_W=64 full run:
  - round 0: K=64'h428a2f98d728ae22;
  - round 79: K=64'h6c44198c4a475817 with last=1;
  - 80 valid cycles total, then one done pulse.
- WORD_W=32, stall held 3 cycles at round 10: round_idx=10 and K=32'h243185be stay constant for all 4 cycles; round 11 then shows K=32'h550c7dc3.
- Stall at round 63 for 2 cycles: last stays 1 and done does not assert until the first unstalled cycle.
- Abort with stall=1 at round 20: next cycle k_valid=0, busy=0, round_idx=0, done never pulses. A new start then begins again from round 0.
- Control-corner cases:
  - start asserted during RUN and during DONE is ignored, with no sequence restart;
  - synchronous reset at round 40 gives all outputs at their reset values on the next edge.
